// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with write bypass,
// pending-write scoreboard and a post-reset clearing sweep.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 2,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   ready,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*XLEN-1:0]  rd_data,
  output logic [NREAD-1:0]       rd_busy,
  input  logic [NWRITE-1:0]      wr_en,
  input  logic [NWRITE*AW-1:0]   wr_addr,
  input  logic [NWRITE*XLEN-1:0] wr_data,
  input  logic                   alloc_en,
  input  logic [AW-1:0]          alloc_addr,
  output logic [NREGS-1:0]       busy_vec
);

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]      state;
  logic [AW-1:0]   cnt;
  logic [XLEN-1:0] mem [NREGS];
  logic [NREGS-1:0] busy_q;
  logic            run;
  logic [NWRITE-1:0] wr_ok;
  logic            alloc_ok;
  logic [AW-1:0]   ra;

  assign run      = (state == S_RUN);
  assign ready    = run;
  assign busy_vec = busy_q;

  always_comb begin
    wr_ok = '0;
    for (int j = 0; j < NWRITE; j++) begin
      wr_ok[j] = run && wr_en[j] &&
                 !(ZERO_REG && (wr_addr[j*AW +: AW] == '0));
    end
  end

  assign alloc_ok = run && alloc_en &&
                    !(ZERO_REG && (alloc_addr == '0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_INIT;
      cnt    <= '0;
      busy_q <= '0;
    end else if (!run) begin
      cnt <= cnt + AW'(1);
      if (cnt == AW'(NREGS-1)) state <= S_RUN;
    end else begin
      for (int j = 0; j < NWRITE; j++) begin
        if (wr_ok[j]) busy_q[wr_addr[j*AW +: AW]] <= 1'b0;
      end
      // a fresh producer outranks a retiring one
      if (alloc_ok) busy_q[alloc_addr] <= 1'b1;
    end
  end

  // storage has no reset so it can map onto RAM
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (!run) begin
        mem[cnt] <= '0;
      end else begin
        for (int j = 0; j < NWRITE; j++) begin
          if (wr_ok[j])
            mem[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    for (int i = 0; i < NREAD; i++) begin
      ra = rd_addr[i*AW +: AW];
      if (run && !(ZERO_REG && (ra == '0))) begin
        rd_data[i*XLEN +: XLEN] = mem[ra];
        rd_busy[i]              = busy_q[ra];
        if (BYPASS) begin
          for (int j = 0; j < NWRITE; j++) begin
            if (wr_ok[j] && (wr_addr[j*AW +: AW] == ra)) begin
              rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
              rd_busy[i] = alloc_ok && (alloc_addr == ra);
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vectors for regfile_mp, run on a bypass
// and a non-bypass instance driven by the same stimulus.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2*AW-1:0]   rd_addr;
  logic [1:0]        wr_en;
  logic [2*AW-1:0]   wr_addr;
  logic [2*XLEN-1:0] wr_data;
  logic              alloc_en;
  logic [AW-1:0]     alloc_addr;

  logic              ready_b, ready_n;
  logic [2*XLEN-1:0] rd_data_b, rd_data_n;
  logic [1:0]        rd_busy_b, rd_busy_n;
  logic [NREGS-1:0]  busy_vec_b, busy_vec_n;

  regfile_mp #(.BYPASS(1'b1)) u_byp (
    .clk(clk), .rst_n(rst_n), .ready(ready_b),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .busy_vec(busy_vec_b)
  );

  regfile_mp #(.BYPASS(1'b0)) u_nob (
    .clk(clk), .rst_n(rst_n), .ready(ready_n),
    .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .busy_vec(busy_vec_n)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] we,
                       input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic ae, input logic [4:0] aa,
                       input logic [4:0] ra0, input logic [4:0] ra1);
    wr_en      = we;
    wr_addr    = {wa1, wa0};
    wr_data    = {wd1, wd0};
    alloc_en   = ae;
    alloc_addr = aa;
    rd_addr    = {ra1, ra0};
  endtask

  task automatic idle();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  // writes/allocs to reg4 held during INIT must all be dropped
  task automatic init_noise();
    drive(2'b11, 5'd4, 32'hFF, 5'd4, 32'hFF, 1'b1, 5'd4, 5'd4, 5'd31);
  endtask

  task automatic sweep_check(input string tag);
    for (int k = 1; k <= NREGS; k++) begin
      @(posedge clk);
      #1;
      if (k < NREGS) begin
        chk({tag, "_ready_lo"}, 64'(ready_b), 64'd0);
        chk({tag, "_rd_zero"}, rd_data_b, 64'd0);
        chk({tag, "_busy_zero"}, 64'(rd_busy_b), 64'd0);
        chk({tag, "_rd_zero_nb"}, rd_data_n, 64'd0);
      end else begin
        idle();
        chk({tag, "_ready_hi"}, 64'(ready_b), 64'd1);
        chk({tag, "_ready_hi_nb"}, 64'(ready_n), 64'd1);
      end
    end
  endtask

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        ae;
    logic [4:0]  aa;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        b0;
    logic        b1;
    logic [31:0] n0;
    logic [31:0] n1;
    logic [31:0] bv;
  } vec_t;

  vec_t v [16];

  initial begin
    v[0]  = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0,
              32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
    v[1]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0,
              32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0, 32'h0};
    v[2]  = '{2'b01, 5'd0, 32'h1234, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd5,
              32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'hDEADBEEF, 32'h0};
    v[3]  = '{2'b10, 5'd0, 32'h0, 5'd0, 32'h1234, 1'b0, 5'd0, 5'd0, 5'd5,
              32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'hDEADBEEF, 32'h0};
    v[4]  = '{2'b11, 5'd7, 32'hAAAA, 5'd7, 32'h5555, 1'b0, 5'd0, 5'd7, 5'd7,
              32'h5555, 32'h5555, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
    v[5]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7,
              32'h5555, 32'h5555, 1'b0, 1'b0, 32'h5555, 32'h5555, 32'h0};
    v[6]  = '{2'b01, 5'd9, 32'h77, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd9,
              32'h5555, 32'h77, 1'b0, 1'b0, 32'h5555, 32'h0, 32'h0};
    v[7]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd9,
              32'h5555, 32'h77, 1'b0, 1'b0, 32'h5555, 32'h77, 32'h0};
    v[8]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd9,
              32'h0, 32'h77, 1'b0, 1'b0, 32'h0, 32'h77, 32'h0};
    v[9]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd9,
              32'h0, 32'h77, 1'b1, 1'b0, 32'h0, 32'h77, 32'h8};
    v[10] = '{2'b01, 5'd3, 32'h11, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3,
              32'h11, 32'h11, 1'b0, 1'b0, 32'h0, 32'h0, 32'h8};
    v[11] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3,
              32'h11, 32'h11, 1'b0, 1'b0, 32'h11, 32'h11, 32'h0};
    v[12] = '{2'b10, 5'd0, 32'h0, 5'd3, 32'h22, 1'b1, 5'd3, 5'd3, 5'd7,
              32'h22, 32'h5555, 1'b1, 1'b0, 32'h11, 32'h5555, 32'h0};
    v[13] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd7,
              32'h22, 32'h5555, 1'b1, 1'b0, 32'h22, 32'h5555, 32'h8};
    v[14] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd3,
              32'h0, 32'h22, 1'b0, 1'b1, 32'h0, 32'h22, 32'h8};
    v[15] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd3,
              32'h0, 32'h22, 1'b0, 1'b1, 32'h0, 32'h22, 32'h8};

    init_noise();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(ready_b), 64'd0);
    chk("rst_busy_vec", 64'(busy_vec_b), 64'd0);
    chk("rst_rd_data", rd_data_b, 64'd0);
    rst_n = 1'b1;
    sweep_check("sweep1");

    for (int i = 0; i < NREGS; i++) begin
      rd_addr = {5'(i), 5'(i)};
      #1;
      chk($sformatf("clear_r%0d", i), rd_data_b, 64'd0);
    end
    chk("clear_busy_vec", 64'(busy_vec_b), 64'd0);

    init_noise();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_ready_lo", 64'(ready_b), 64'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_ready", 64'(ready_b), 64'd0);
    rst_n = 1'b1;
    sweep_check("sweep2");

    rd_addr = {5'd4, 5'd4};
    #1;
    chk("drop_r4", rd_data_b, 64'd0);
    chk("drop_busy4", 64'(busy_vec_b[4]), 64'd0);
    chk("drop_busy_vec_nb", 64'(busy_vec_n), 64'd0);

    for (int k = 0; k < 16; k++) begin
      drive(v[k].we, v[k].wa0, v[k].wd0, v[k].wa1, v[k].wd1,
            v[k].ae, v[k].aa, v[k].ra0, v[k].ra1);
      #1;
      chk($sformatf("v%0d_d0", k), 64'(rd_data_b[31:0]), 64'(v[k].d0));
      chk($sformatf("v%0d_d1", k), 64'(rd_data_b[63:32]), 64'(v[k].d1));
      chk($sformatf("v%0d_b0", k), 64'(rd_busy_b[0]), 64'(v[k].b0));
      chk($sformatf("v%0d_b1", k), 64'(rd_busy_b[1]), 64'(v[k].b1));
      chk($sformatf("v%0d_n0", k), 64'(rd_data_n[31:0]), 64'(v[k].n0));
      chk($sformatf("v%0d_n1", k), 64'(rd_data_n[63:32]), 64'(v[k].n1));
      chk($sformatf("v%0d_bv", k), 64'(busy_vec_b), 64'(v[k].bv));
      chk($sformatf("v%0d_bv_nb", k), 64'(busy_vec_n), 64'(v[k].bv));
      @(posedge clk);
      #1;
    end

    idle();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the RV32I core and its successors. It has configurable data width, depth, read-port count and write-port count, with optional write-to-read bypass and a per-register pending-write scoreboard for hazard detection. After reset it clears storage with a one-register-per-cycle sweep, so it maps onto RAM-style storage instead of a flop-wide reset. It sits between decode (reads, allocation) and writeback (writes).

## Interface
- XLEN, 32, data width in bits.
- NREGS, 32, number of registers; power of two, ≥2. AW = $clog2(NREGS).
- NREAD, 2, number of read ports, ≥1.
- NWRITE, 2, number of write ports, ≥1.
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = no forwarding.
- ZERO_REG, 1, 1 = register 0 is hardwired to zero.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ready  out  1  high once the init sweep is complete.
- rd_addr  in  NREAD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NREAD*XLEN  read data per port.
- rd_busy  out  NREAD  per-port flag: register has a pending write.
- wr_en  in  NWRITE  per-port write enable.
- wr_addr  in  NWRITE*AW  write addresses.
- wr_data  in  NWRITE*XLEN  write data.
- alloc_en  in  1  mark the register at alloc_addr pending.
- alloc_addr  in  AW  register to mark pending.
- busy_vec  out  NREGS  raw scoreboard state.

## Operation
- FSM has two states, INIT and RUN.
- rst_n low at an edge:
  - state to INIT, sweep counter to 0, busy_vec to 0, ready to 0.
  - Storage contents are not touched by the reset edge itself.
- INIT, on each edge with rst_n high:
  - reg[cnt] is set to 0 and cnt increments.
  - When cnt == NREGS-1 is cleared, state goes to RUN.
- During INIT:
  - wr_en and alloc_en are ignored.
  - rd_data is all zeros and rd_busy is all zeros.
- Reset asserted mid-sweep restarts the sweep from 0.
- Write, RUN only:
  - A port writes when wr_en[j]=1 and the address is not 0 under ZERO_REG.
  - If several ports hit the same address, the highest-index port wins.
  - Each write clears busy for its address.
- Allocation, RUN only:
  - alloc_en=1 with a nonzero address (under ZERO_REG) sets busy.
  - If alloc and write hit the same address in the same cycle, alloc wins and busy ends at 1, because a new producer exists.
- Read, combinational, per port:
  - Address 0 under ZERO_REG returns 0 with busy 0.
  - With BYPASS=1, if any accepted write targets the address this cycle:
    - rd_data is the winning port's wr_data.
    - rd_busy is 0, unless alloc_en targets the same address this cycle, in which case rd_busy is 1.
  - Otherwise rd_data is the stored value and rd_busy is the busy bit.
- Writes and allocs while ready=0 are dropped silently.

## Timing
- Reset values:
  - ready=0, busy_vec=0.
  - rd_data=0 and rd_busy=0 throughout INIT.
- Init sweep:
  - ready rises after exactly NREGS clock edges with rst_n high following release.
  - With NREGS=32, that is at the 32nd edge.
- Read latency:
  - 0 cycles, combinational from rd_addr.
  - A stored write is visible at the next edge (BYPASS=0), or in the same cycle (BYPASS=1).
- Scoreboard:
  - busy set or clear takes effect at the edge.
  - busy_vec is registered; it has no bypass.

## Test plan
- Reset and sweep, NREGS=32:
  - Hold rst_n low 2 cycles, then release.
  - ready=0 for 31 edges and 1 after the 32nd.
  - All 32 registers then read 0.
  - Re-assert rst_n at cnt=10: ready stays 0 and the sweep restarts; ready rises 32 edges after the second release.
- Basic write/read:
  - Write reg5=0xDEADBEEF on port 0.
  - The next cycle rd_addr0=5 gives 0xDEADBEEF.
  - A write of 0x1234 to reg0 leaves reg0 reading 0.
- Write conflict:
  - Same cycle: port0 writes reg7=0xAAAA and port1 writes reg7=0x5555.
  - reg7 afterwards reads 0x5555.
- Bypass:
  - BYPASS=1: writing reg9=0x77 with rd_addr1=9 in the same cycle gives rd_data1=0x77.
  - BYPASS=0: the same stimulus returns the old value (0) that cycle and 0x77 the next cycle.
- Scoreboard:
  - Alloc reg3, then busy_vec[3]=1 and rd_busy=1.
  - A later write to reg3 clears it.
  - Simultaneous alloc and write to reg3 leaves busy_vec[3]=1 with the new data stored.
  - Alloc to reg0 has no effect.
- Pre-ready drop:
  - Writing reg4=0xFF and allocating reg4 during INIT leaves reg4=0 and busy_vec[4]=0 after ready.
